pe_feeder: RTL and testbench
============================

Name: pe_feeder

Overview:
- Initiator-side sequencer that drives a single PE's instruction and data inputs (inst_in_v/inst_in, din_pe_v/din_pe, alpha_v).
- The host preloads a program into an instruction buffer and operands into a data buffer, then pulses start.
- The block then issues every instruction back-to-back, waits a programmable gap, and streams every data word back-to-back.
- It sits between the host/control fabric and the pe instance, in place of hand-driven stimulus.

Parameters:
- DATA_WIDTH, 16, component width; a complex word is DATA_WIDTH*2 bits (imag in upper half, real in lower half).
- INST_WIDTH, 32, PE instruction width.
- INST_DEPTH, 16, instruction buffer entries (power of 2).
- DATA_DEPTH, 16, data buffer entries (power of 2).
- GAP_CYCLES, 2, idle cycles between the last instruction and the first data beat (0 allowed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- inst_wr_v  in  1  host instruction write strobe.
- inst_wr  in  INST_WIDTH  instruction to append.
- inst_wr_rdy  out  1  high when in IDLE and the instruction buffer is not full.
- inst_clr  in  1  in IDLE, empties the instruction buffer.
- data_wr_v  in  1  host data write strobe.
- data_wr  in  DATA_WIDTH*2  complex word to append.
- data_wr_rdy  out  1  high when in IDLE and the data buffer is not full.
- alpha_en  in  1  sampled at start; requests an alpha_v pulse.
- start  in  1  one-cycle launch pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence end.
- inst_in_v  out  1  instruction valid to the PE.
- inst_in  out  INST_WIDTH  instruction to the PE.
- din_pe_v  out  1  data valid to the PE.
- din_pe  out  DATA_WIDTH*2  data to the PE.
- alpha_v  out  1  alpha strobe to the PE.

Behaviour:
- Reset: every output is 0 (inst_wr_rdy and data_wr_rdy are also 0 while reset is asserted). Both buffers are emptied, pointers and counts cleared, and the FSM is set to IDLE. Reset may be asserted mid-sequence; outputs drop to 0 immediately (asynchronous) and no done pulse is produced.
- Buffer writes:
  - A write is accepted when the strobe and the corresponding rdy are both high. It lands at index = count, and count increments.
  - A write while rdy is low is dropped silently. Counts saturate at DEPTH.
  - A write in the same cycle as an accepted start is accepted and included in the sequence.
- inst_clr in the same cycle as inst_wr_v: clear wins and the write is dropped. inst_clr outside IDLE is ignored.
- FSM states and transitions:
  - IDLE: start=1 moves to INST if inst_cnt>0. Otherwise it moves to GAP if GAP_CYCLES>0, else DATA if data_cnt>0, else DONE. start outside IDLE is ignored.
  - INST: issues one instruction per cycle, index 0..inst_cnt-1. After the last one it goes to GAP (or DATA/DONE by the same skip rules).
  - GAP: exactly GAP_CYCLES cycles with all valids low, then DATA if data_cnt>0, else DONE.
  - DATA: issues one word per cycle, index 0..data_cnt-1, then DONE.
  - DONE: one cycle with done=1, then IDLE. data_cnt is cleared. inst_cnt is retained, so the next start replays the same program.
- Output timing:
  - All PE-side outputs are registered.
  - With start high at edge k, the first inst_in_v is high in the cycle after edge k+1.
  - Total busy cycles = 1 + inst_cnt + GAP_CYCLES + data_cnt + 1 (the leading 1 is the launch cycle; the trailing 1 is DONE).
  - inst_in and din_pe are 0 whenever their valid is low.
  - inst_in_v and din_pe_v are never high in the same cycle.
- alpha_v: when alpha_en was 1 at start, alpha_v=1 for exactly the first DATA beat. If data_cnt=0, alpha_v never asserts.
- Pointers: the read index wraps by the power-of-2 width. A full buffer (count=DEPTH) issues all DEPTH entries in order.

Test Plan:
- Reset with GAP_CYCLES=2:
  - Load 32'h60010080, 32'h60030281, 32'h60050482.
  - Load data 32'h00040002, 32'h00030001, 32'h00080006, 32'h00070005, 32'h000C000A, 32'h000B0009.
  - Pulse start.
  - Required: inst_in_v high for 3 consecutive cycles in write order, then 2 idle cycles, then din_pe_v high for 6 cycles in order.
  - Required: done pulses one cycle after the last beat; busy is high for 13 cycles.
- alpha_en=1 with 2 data words: alpha_v is high only with din_pe=first word.
- No alpha_v when alpha_en=1 and data_cnt=0.
- Zero instructions, 2 data words, GAP_CYCLES=0: din_pe_v is first high in the cycle after start+1; no inst_in_v ever.
- Replay and clear:
  - A second start after done, with no new writes, replays the 3 instructions with no data beats.
  - inst_clr followed by start gives busy high for 2+GAP_CYCLES cycles only.
- Full buffers:
  - Write 17 instructions (DEPTH 16): inst_wr_rdy drops after the 16th write and the 17th is not issued.
  - inst_wr_v and data_wr_v writes during busy are dropped.
- Reset mid-stream:
  - Assert rst=0 during the DATA state: all outputs go to 0 before the next edge, there is no done pulse, and both counts read 0.
  - After release, a fresh load plus start behaves as in the first scenario.

Source files
------------

// File: rtl/pe_feeder_if.sv
// PE-side instruction/data bus driven by pe_feeder (master) into a single PE (slave).
interface pe_feeder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INST_WIDTH = 32
) ();
  logic                    inst_in_v;
  logic [INST_WIDTH-1:0]   inst_in;
  logic                    din_pe_v;
  logic [2*DATA_WIDTH-1:0] din_pe;
  logic                    alpha_v;

  modport master (
    output inst_in_v,
    output inst_in,
    output din_pe_v,
    output din_pe,
    output alpha_v
  );

  modport slave (
    input inst_in_v,
    input inst_in,
    input din_pe_v,
    input din_pe,
    input alpha_v
  );
endinterface

// File: rtl/pe_feeder.sv
// Host-loaded sequencer: replays an instruction buffer, waits a fixed gap, then streams a data
// buffer into one PE. All PE-side outputs come straight from flops.
module pe_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_DEPTH = 16,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_wr_v,
  input  logic [INST_WIDTH-1:0]   inst_wr,
  output logic                    inst_wr_rdy,
  input  logic                    inst_clr,
  input  logic                    data_wr_v,
  input  logic [2*DATA_WIDTH-1:0] data_wr,
  output logic                    data_wr_rdy,
  input  logic                    alpha_en,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  pe_feeder_if.master             pe
);

  localparam int unsigned IAW  = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1;
  localparam int unsigned DAW  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned ICW  = $clog2(INST_DEPTH + 1);
  localparam int unsigned DCW  = $clog2(DATA_DEPTH + 1);
  localparam int unsigned IdxW = (ICW > DCW) ? ICW : DCW;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StLaunch, StInst, StGap, StData, StDone} state_e;

  state_e                  state_q, state_d, after_inst;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic [ICW-1:0]          inst_cnt_q, inst_cnt_d;
  logic [DCW-1:0]          data_cnt_q, data_cnt_d;
  logic                    alpha_req_q;
  logic                    inst_rdy_q, inst_rdy_d, data_rdy_q, data_rdy_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    inst_v_q, inst_v_d, data_v_q, data_v_d, alpha_q, alpha_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [2*DATA_WIDTH-1:0] din_q, din_d;
  logic                    idle, inst_we, data_we, last_inst, last_data;

  logic [INST_WIDTH-1:0]   inst_mem [INST_DEPTH];
  logic [2*DATA_WIDTH-1:0] data_mem [DATA_DEPTH];

  assign idle = (state_q == StIdle);
  // Clear takes priority over a same-cycle append.
  assign inst_we = inst_wr_v && inst_rdy_q && !(inst_clr && idle);
  assign data_we = data_wr_v && data_rdy_q;

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    if (idle && inst_clr) begin
      inst_cnt_d = '0;
    end else if (inst_we) begin
      inst_cnt_d = inst_cnt_q + ICW'(1);
    end
  end

  always_comb begin
    data_cnt_d = data_cnt_q;
    if (state_q == StDone) begin
      data_cnt_d = '0;
    end else if (data_we) begin
      data_cnt_d = data_cnt_q + DCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (inst_we) inst_mem[inst_cnt_q[IAW-1:0]] <= inst_wr;
    if (data_we) data_mem[data_cnt_q[DAW-1:0]] <= data_wr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt_q  <= '0;
      data_cnt_q  <= '0;
      alpha_req_q <= 1'b0;
    end else begin
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      if (idle && start) alpha_req_q <= alpha_en;
    end
  end

  assign last_inst = (idx_q + IdxW'(1)) == IdxW'(inst_cnt_q);
  assign last_data = (idx_q + IdxW'(1)) == IdxW'(data_cnt_q);

  always_comb begin
    after_inst = StDone;
    if (GAP_CYCLES != 0) begin
      after_inst = StGap;
    end else if (data_cnt_q != '0) begin
      after_inst = StData;
    end
  end

  // Launch decides the route so that writes accepted alongside start are counted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLaunch;
      end
      StLaunch: begin
        idx_d   = '0;
        gap_d   = '0;
        state_d = (inst_cnt_q != '0) ? StInst : after_inst;
      end
      StInst: begin
        if (last_inst) begin
          state_d = after_inst;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = (data_cnt_q != '0) ? StData : StDone;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StData: begin
        if (last_data) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with the state they describe.
  always_comb begin
    inst_v_d   = (state_d == StInst);
    data_v_d   = (state_d == StData);
    inst_d     = inst_v_d ? inst_mem[idx_d[IAW-1:0]] : '0;
    din_d      = data_v_d ? data_mem[idx_d[DAW-1:0]] : '0;
    alpha_d    = data_v_d && alpha_req_q && (idx_d == '0);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    inst_rdy_d = (state_d == StIdle) && (inst_cnt_d != ICW'(INST_DEPTH));
    data_rdy_d = (state_d == StIdle) && (data_cnt_d != DCW'(DATA_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      gap_q      <= '0;
      inst_v_q   <= 1'b0;
      inst_q     <= '0;
      data_v_q   <= 1'b0;
      din_q      <= '0;
      alpha_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inst_rdy_q <= 1'b0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      inst_v_q   <= inst_v_d;
      inst_q     <= inst_d;
      data_v_q   <= data_v_d;
      din_q      <= din_d;
      alpha_q    <= alpha_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inst_rdy_q <= inst_rdy_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  assign pe.inst_in_v = inst_v_q;
  assign pe.inst_in   = inst_q;
  assign pe.din_pe_v  = data_v_q;
  assign pe.din_pe    = din_q;
  assign pe.alpha_v   = alpha_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign inst_wr_rdy  = inst_rdy_q;
  assign data_wr_rdy  = data_rdy_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: dut A uses a 2-cycle gap, dut B a zero gap.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_wr_v = 1'b0, inst_clr = 1'b0, data_wr_v = 1'b0;
  logic        alpha_en = 1'b0, start = 1'b0;
  logic [31:0] inst_wr = '0, data_wr = '0;
  logic        a_inst_rdy, a_data_rdy, a_busy, a_done;
  logic        b_zero = 1'b0, b_data_wr_v = 1'b0, b_start = 1'b0;
  logic        b_inst_rdy, b_data_rdy, b_busy, b_done;

  pe_feeder_if #(.DATA_WIDTH(16), .INST_WIDTH(32)) pe_a ();
  pe_feeder_if #(.DATA_WIDTH(16), .INST_WIDTH(32)) pe_b ();

  pe_feeder #(.GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .inst_wr_v(inst_wr_v), .inst_wr(inst_wr), .inst_wr_rdy(a_inst_rdy),
    .inst_clr(inst_clr), .data_wr_v(data_wr_v), .data_wr(data_wr), .data_wr_rdy(a_data_rdy),
    .alpha_en(alpha_en), .start(start), .busy(a_busy), .done(a_done), .pe(pe_a)
  );

  pe_feeder #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .inst_wr_v(b_zero), .inst_wr(inst_wr), .inst_wr_rdy(b_inst_rdy),
    .inst_clr(b_zero), .data_wr_v(b_data_wr_v), .data_wr(data_wr), .data_wr_rdy(b_data_rdy),
    .alpha_en(alpha_en), .start(b_start), .busy(b_busy), .done(b_done), .pe(pe_b)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cap_n;
  logic [68:0] obs [64];
  logic [31:0] prog_i [16];
  logic [31:0] prog_d [16];

  // Expected {busy, inst_v, inst, din_v, din, alpha, done} for cycle i after the start edge.
  function automatic logic [68:0] exp_at(int i, int ni, int gap, int nd, bit al);
    logic b, iv, dv, a, dn;
    logic [31:0] ins, d;
    int j;
    b = 1'b0; iv = 1'b0; dv = 1'b0; a = 1'b0; dn = 1'b0; ins = '0; d = '0;
    j = i - 1;
    if (i == 0) b = 1'b1;
    else if (j < ni) begin b = 1'b1; iv = 1'b1; ins = prog_i[j]; end
    else if (j < ni + gap) b = 1'b1;
    else if (j < ni + gap + nd) begin
      b = 1'b1; dv = 1'b1; d = prog_d[j - ni - gap]; a = al && (j == ni + gap);
    end else if (j == ni + gap + nd) begin b = 1'b1; dn = 1'b1; end
    return {b, iv, ins, dv, d, a, dn};
  endfunction

  task automatic write_inst(input logic [31:0] v);
    inst_wr = v; inst_wr_v = 1'b1;
    @(posedge clk); #1;
    inst_wr_v = 1'b0;
  endtask

  task automatic write_data(input logic [31:0] v);
    data_wr = v; data_wr_v = 1'b1;
    @(posedge clk); #1;
    data_wr_v = 1'b0;
  endtask

  task automatic pulse_start(input logic al);
    start = 1'b1; alpha_en = al;
    @(posedge clk); #1;
    start = 1'b0; alpha_en = 1'b0;
  endtask

  task automatic clear_inst();
    inst_clr = 1'b1;
    @(posedge clk); #1;
    inst_clr = 1'b0;
  endtask

  task automatic capture(input bit sel_b);
    logic bsy;
    cap_n = 0;
    for (int i = 0; i < 64; i++) obs[i] = 'x;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sel_b) begin
        bsy = b_busy;
        obs[i] = {b_busy, pe_b.inst_in_v, pe_b.inst_in, pe_b.din_pe_v, pe_b.din_pe,
                  pe_b.alpha_v, b_done};
      end else begin
        bsy = a_busy;
        obs[i] = {a_busy, pe_a.inst_in_v, pe_a.inst_in, pe_a.din_pe_v, pe_a.din_pe,
                  pe_a.alpha_v, a_done};
      end
      if (bsy) cap_n++;
      else break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({a_busy, a_done, a_inst_rdy, a_data_rdy, pe_a.inst_in_v, pe_a.inst_in, pe_a.din_pe_v,
         pe_a.din_pe, pe_a.alpha_v} !== '0) begin
      bad++; $display("FAIL reset_outputs_a: some output nonzero, busy=%b rdy=%b%b", a_busy,
                      a_inst_rdy, a_data_rdy);
    end
    total++;
    if ({b_busy, b_done, b_inst_rdy, b_data_rdy, pe_b.inst_in_v, pe_b.din_pe_v,
         pe_b.alpha_v} !== '0) begin
      bad++; $display("FAIL reset_outputs_b: some output nonzero, busy=%b", b_busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_inst_rdy, a_data_rdy} !== 2'b11) begin
      bad++; $display("FAIL rdy_after_reset: got=%b%b exp=11", a_inst_rdy, a_data_rdy);
    end
  endtask

  task automatic test_basic(input string tag);
    prog_i[0] = 32'h60010080; prog_i[1] = 32'h60030281; prog_i[2] = 32'h60050482;
    prog_d[0] = 32'h00040002; prog_d[1] = 32'h00030001; prog_d[2] = 32'h00080006;
    prog_d[3] = 32'h00070005; prog_d[4] = 32'h000C000A; prog_d[5] = 32'h000B0009;
    for (int i = 0; i < 3; i++) write_inst(prog_i[i]);
    for (int i = 0; i < 6; i++) write_data(prog_d[i]);
    pulse_start(1'b0);
    capture(1'b0);
    total++;
    if (cap_n !== 13) begin
      bad++; $display("FAIL %s busy_cycles: got=%0d exp=13", tag, cap_n);
    end
    for (int i = 0; i <= 13; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 3, 2, 6, 1'b0)) begin
        bad++; $display("FAIL %s trace cyc=%0d got=%h exp=%h", tag, i, obs[i],
                        exp_at(i, 3, 2, 6, 1'b0));
      end
    end
  endtask

  task automatic test_alpha();
    prog_d[0] = 32'h00110010; prog_d[1] = 32'h00130012;
    write_data(prog_d[0]);
    write_data(prog_d[1]);
    pulse_start(1'b1);
    capture(1'b0);
    total++;
    if (cap_n !== 9) begin
      bad++; $display("FAIL alpha busy_cycles: got=%0d exp=9", cap_n);
    end
    for (int i = 0; i <= 9; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 3, 2, 2, 1'b1)) begin
        bad++; $display("FAIL alpha trace cyc=%0d got=%h exp=%h", i, obs[i],
                        exp_at(i, 3, 2, 2, 1'b1));
      end
    end
  endtask

  // Replay of the retained program with alpha requested but no data loaded.
  task automatic test_replay_no_alpha();
    pulse_start(1'b1);
    capture(1'b0);
    total++;
    if (cap_n !== 7) begin
      bad++; $display("FAIL replay busy_cycles: got=%0d exp=7", cap_n);
    end
    for (int i = 0; i <= 7; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 3, 2, 0, 1'b1)) begin
        bad++; $display("FAIL replay trace cyc=%0d got=%h exp=%h", i, obs[i],
                        exp_at(i, 3, 2, 0, 1'b1));
      end
    end
  endtask

  task automatic test_clear();
    inst_clr = 1'b1; inst_wr_v = 1'b1; inst_wr = 32'h0BAD0BAD;
    @(posedge clk); #1;
    inst_clr = 1'b0; inst_wr_v = 1'b0;
    pulse_start(1'b0);
    capture(1'b0);
    total++;
    if (cap_n !== 4) begin
      bad++; $display("FAIL clear busy_cycles: got=%0d exp=4", cap_n);
    end
    for (int i = 0; i <= 4; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 0, 2, 0, 1'b0)) begin
        bad++; $display("FAIL clear trace cyc=%0d got=%h exp=%h", i, obs[i],
                        exp_at(i, 0, 2, 0, 1'b0));
      end
    end
  endtask

  task automatic test_zero_inst();
    prog_d[0] = 32'h00020001; prog_d[1] = 32'h00040003;
    for (int i = 0; i < 2; i++) begin
      data_wr = prog_d[i]; b_data_wr_v = 1'b1;
      @(posedge clk); #1;
      b_data_wr_v = 1'b0;
    end
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    capture(1'b1);
    total++;
    if (cap_n !== 4) begin
      bad++; $display("FAIL zero_inst busy_cycles: got=%0d exp=4", cap_n);
    end
    for (int i = 0; i <= 4; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 0, 0, 2, 1'b0)) begin
        bad++; $display("FAIL zero_inst trace cyc=%0d got=%h exp=%h", i, obs[i],
                        exp_at(i, 0, 0, 2, 1'b0));
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      prog_i[i] = 32'hA0000000 + 32'(i);
      write_inst(prog_i[i]);
      if (i == 14) begin
        total++;
        if (a_inst_rdy !== 1'b1) begin
          bad++; $display("FAIL full_rdy_before_last: got=%b exp=1", a_inst_rdy);
        end
      end
    end
    total++;
    if (a_inst_rdy !== 1'b0) begin
      bad++; $display("FAIL full_rdy_after_16: got=%b exp=0", a_inst_rdy);
    end
    write_inst(32'hDEADBEEF);
    pulse_start(1'b0);
    fork
      capture(1'b0);
      begin
        inst_wr = 32'hBAD0BAD0; inst_wr_v = 1'b1;
        data_wr = 32'h12345678; data_wr_v = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        inst_wr_v = 1'b0; data_wr_v = 1'b0;
      end
    join
    for (int run = 0; run < 2; run++) begin
      if (run == 1) begin
        pulse_start(1'b0);
        capture(1'b0);
      end
      total++;
      if (cap_n !== 20) begin
        bad++; $display("FAIL full run%0d busy_cycles: got=%0d exp=20", run, cap_n);
      end
      for (int i = 0; i <= 20; i++) begin
        total++;
        if (obs[i] !== exp_at(i, 16, 2, 0, 1'b0)) begin
          bad++; $display("FAIL full run%0d trace cyc=%0d got=%h exp=%h", run, i, obs[i],
                          exp_at(i, 16, 2, 0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_inst();
    prog_i[0] = 32'h11110000; prog_i[1] = 32'h22220000; prog_i[2] = 32'h33330000;
    prog_d[0] = 32'h00AA0055;
    for (int i = 0; i < 3; i++) write_inst(prog_i[i]);
    for (int i = 0; i < 4; i++) write_data(prog_d[0] + 32'(i));
    pulse_start(1'b0);
    repeat (7) @(negedge clk);
    total++;
    if ({pe_a.din_pe_v, pe_a.din_pe} !== {1'b1, prog_d[0]}) begin
      bad++; $display("FAIL midstream_first_beat: got=%b/%h exp=1/%h", pe_a.din_pe_v,
                      pe_a.din_pe, prog_d[0]);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({a_busy, a_done, a_inst_rdy, a_data_rdy, pe_a.inst_in_v, pe_a.inst_in, pe_a.din_pe_v,
         pe_a.din_pe, pe_a.alpha_v} !== '0) begin
      bad++; $display("FAIL midstream_async_clear: busy=%b dv=%b din=%h", a_busy,
                      pe_a.din_pe_v, pe_a.din_pe);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({a_done, a_busy} !== 2'b00) begin
        bad++; $display("FAIL midstream_no_done cyc=%0d: done/busy got=%b%b exp=00", i,
                        a_done, a_busy);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_inst_rdy, a_data_rdy} !== 2'b11) begin
      bad++; $display("FAIL midstream_rdy: got=%b%b exp=11", a_inst_rdy, a_data_rdy);
    end
    pulse_start(1'b0);
    capture(1'b0);
    total++;
    if (cap_n !== 4) begin
      bad++; $display("FAIL midstream_counts_cleared busy_cycles: got=%0d exp=4", cap_n);
    end
    for (int i = 0; i <= 4; i++) begin
      total++;
      if (obs[i] !== exp_at(i, 0, 2, 0, 1'b0)) begin
        bad++; $display("FAIL midstream_empty trace cyc=%0d got=%h exp=%h", i, obs[i],
                        exp_at(i, 0, 2, 0, 1'b0));
      end
    end
    test_basic("basic_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_alpha();
    test_replay_no_alpha();
    test_clear();
    test_zero_inst();
    test_full();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
